hpm_counter_bank: RTL and testbench

- Parametrised hardware performance-monitor bank that replaces the fixed one-counter-per-event perf block.
- Holds NR_COUNTERS programmable counters. Each counter selects one of NR_EVENTS event sources and adds a multi-bit increment per cycle, so multi-port commit events are counted exactly.
- Provides per-counter inhibit, sticky overflow flags and an overflow interrupt.
- Sits beside the CSR file, which reads and writes it through an SRAM-like port.

---
 rtl/perf_pkg.sv | 40 ++++
 rtl/hpm_counter_bank_if.sv | 19 +
 rtl/hpm_counter.sv | 89 ++++++++
 rtl/hpm_counter_bank.sv | 144 ++++++++++++++
 tb/tb_hpm_counter_bank.sv | 263 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/perf_pkg.sv
// Shared types and constants for the hardware performance-monitor bank.
// Holds the event index map, the register-class encoding of the CSR-side
// port and the control register indices.
package perf_pkg;

  // Event source indices; index 0 is reserved and never counts.
  typedef enum logic [3:0] {
    EV_NONE      = 4'd0,
    EV_L1I_MISS  = 4'd1,
    EV_L1D_MISS  = 4'd2,
    EV_ITLB_MISS = 4'd3,
    EV_DTLB_MISS = 4'd4,
    EV_LOAD      = 4'd5,
    EV_STORE     = 4'd6,
    EV_BRANCH    = 4'd7,
    EV_CALL      = 4'd8,
    EV_RET       = 4'd9,
    EV_EXCEPTION = 4'd10,
    EV_ERET      = 4'd11,
    EV_MISPREDICT= 4'd12,
    EV_SB_FULL   = 4'd13,
    EV_IF_EMPTY  = 4'd14
  } event_e;

  // Register class selected on the CSR-side port.
  typedef enum logic [1:0] {
    RS_COUNTER = 2'd0,
    RS_EVSEL   = 2'd1,
    RS_CONTROL = 2'd2,
    RS_RSVD    = 2'd3
  } reg_sel_e;

  localparam int unsigned ADDR_W = 5;

  // Control register indices (used with RS_CONTROL).
  localparam logic [ADDR_W-1:0] CTRL_INHIBIT = 5'd0;
  localparam logic [ADDR_W-1:0] CTRL_OVF     = 5'd1;
  localparam logic [ADDR_W-1:0] CTRL_OVF_EN  = 5'd2;

endpackage

// File: rtl/hpm_counter_bank_if.sv
// SRAM-like CSR access port of the performance-monitor bank.
//   reg_sel : register class (counter / event select / control)
//   addr    : counter index or control register index
//   we      : write enable
//   wdata   : write data
//   rdata   : read data (old value during a write cycle)
// master = CSR file side, slave = counter bank side.
interface hpm_counter_bank_if #(
  parameter int unsigned CNT_WIDTH = 64
) ();
  perf_pkg::reg_sel_e                 reg_sel;
  logic [perf_pkg::ADDR_W-1:0]        addr;
  logic                               we;
  logic [CNT_WIDTH-1:0]               wdata;
  logic [CNT_WIDTH-1:0]               rdata;

  modport master (output reg_sel, output addr, output we, output wdata, input rdata);
  modport slave  (input reg_sel, input addr, input we, input wdata, output rdata);
endinterface

// File: rtl/hpm_counter.sv
// One programmable counter slice: event select register, increment gating,
// wrap-around adder, carry-out detect and CSR write override.
//   clk_i, rst_ni   : clock, synchronous active-low reset
//   debug_mode_i    : blocks increments
//   inh_i           : per-counter inhibit from the bank
//   cnt_we_i        : counter write strobe (wins over the increment)
//   sel_we_i        : event select write strobe
//   events_i        : packed per-event increments
//   wdata_i         : CSR write data
//   cnt_o, sel_o    : registered counter value and event select
//   ovf_set_o       : carry-out of this cycle's increment
module hpm_counter #(
  parameter int unsigned CNT_WIDTH = 64,
  parameter int unsigned NR_EVENTS = 16,
  parameter int unsigned INC_W     = 2,
  parameter int unsigned SEL_W     = $clog2(NR_EVENTS)
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       debug_mode_i,
  input  logic                       inh_i,
  input  logic                       cnt_we_i,
  input  logic                       sel_we_i,
  input  logic [NR_EVENTS*INC_W-1:0] events_i,
  input  logic [CNT_WIDTH-1:0]       wdata_i,
  output logic [CNT_WIDTH-1:0]       cnt_o,
  output logic [SEL_W-1:0]           sel_o,
  output logic                       ovf_set_o
);

  logic [CNT_WIDTH-1:0] cnt_r, cnt_s;
  logic [SEL_W-1:0]     sel_r, sel_s;
  logic [INC_W-1:0]     inc_s;
  logic [CNT_WIDTH:0]   sum_s;

  // Select the increment of the chosen event, gated by select 0, inhibit and debug.
  always_comb begin
    inc_s = '0;
    if ((sel_r == '0) || inh_i || debug_mode_i) begin
      inc_s = '0;
    end else begin
      inc_s = events_i[32'(sel_r) * INC_W +: INC_W];
    end
  end

  assign sum_s = {1'b0, cnt_r} + {{(CNT_WIDTH + 1 - INC_W){1'b0}}, inc_s};

  // Next counter value; a CSR write replaces the increment and suppresses its carry.
  always_comb begin
    cnt_s     = cnt_r;
    ovf_set_o = 1'b0;
    if (cnt_we_i) begin
      cnt_s     = wdata_i;
      ovf_set_o = 1'b0;
    end else begin
      cnt_s     = sum_s[CNT_WIDTH-1:0];
      ovf_set_o = sum_s[CNT_WIDTH];
    end
  end

  // Next event select; out-of-range selects (checked on the full word) fall back to "no event".
  always_comb begin
    sel_s = sel_r;
    if (sel_we_i) begin
      if (wdata_i < CNT_WIDTH'(NR_EVENTS)) begin
        sel_s = wdata_i[SEL_W-1:0];
      end else begin
        sel_s = '0;
      end
    end else begin
      sel_s = sel_r;
    end
  end

  // Counter and select state.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_r <= '0;
      sel_r <= '0;
    end else begin
      cnt_r <= cnt_s;
      sel_r <= sel_s;
    end
  end

  assign cnt_o = cnt_r;
  assign sel_o = sel_r;

endmodule

// File: rtl/hpm_counter_bank.sv
// Parametrised hardware performance-monitor bank: NR_COUNTERS programmable
// counters, each counting a selectable multi-bit event, with inhibit mask,
// sticky overflow flags (write-1-to-clear) and an overflow interrupt.
//   clk_i, rst_ni : clock, synchronous active-low reset
//   debug_mode_i  : freezes all counters (CSR access still works)
//   events_i      : per-event increments, slice e = [e*INC_W +: INC_W]
//   bus           : CSR-side access port (slave)
//   irq_o         : registered overflow interrupt
module hpm_counter_bank
  import perf_pkg::*;
#(
  parameter int unsigned NR_COUNTERS = 8,
  parameter int unsigned CNT_WIDTH   = 64,
  parameter int unsigned NR_EVENTS   = 16,
  parameter int unsigned INC_W       = 2
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       debug_mode_i,
  input  logic [NR_EVENTS*INC_W-1:0] events_i,
  hpm_counter_bank_if.slave          bus,
  output logic                       irq_o
);

  localparam int unsigned SEL_W  = $clog2(NR_EVENTS);
  localparam int unsigned NR_IDX = 2 ** ADDR_W;
  // Control registers are NR_COUNTERS wide but travel in a CNT_WIDTH word.
  localparam int unsigned RD_W   = (NR_COUNTERS < CNT_WIDTH) ? NR_COUNTERS : CNT_WIDTH;

  logic [NR_COUNTERS-1:0] inh_r, inh_s;
  logic [NR_COUNTERS-1:0] ovf_r, ovf_s;
  logic [NR_COUNTERS-1:0] ovf_en_r, ovf_en_s;
  logic [NR_COUNTERS-1:0] ovf_set_s;
  logic [NR_COUNTERS-1:0] wmask_s;
  logic                   irq_r;
  logic                   ctrl_we_s;
  logic [CNT_WIDTH-1:0]   rdata_s;

  // Read views padded to the full address space; unused indices read as 0.
  logic [CNT_WIDTH-1:0]   cnt_rd_s [NR_IDX];
  logic [CNT_WIDTH-1:0]   sel_rd_s [NR_IDX];

  for (genvar i = 0; i < NR_COUNTERS; i++) begin : g_cnt
    logic [SEL_W-1:0] sel_q_s;
    logic             cnt_we_s;
    logic             sel_we_s;

    assign cnt_we_s = bus.we && (bus.reg_sel == RS_COUNTER) && (bus.addr == ADDR_W'(i));
    assign sel_we_s = bus.we && (bus.reg_sel == RS_EVSEL)   && (bus.addr == ADDR_W'(i));

    hpm_counter #(
      .CNT_WIDTH (CNT_WIDTH),
      .NR_EVENTS (NR_EVENTS),
      .INC_W     (INC_W),
      .SEL_W     (SEL_W)
    ) u_counter (
      .clk_i        (clk_i),
      .rst_ni       (rst_ni),
      .debug_mode_i (debug_mode_i),
      .inh_i        (inh_r[i]),
      .cnt_we_i     (cnt_we_s),
      .sel_we_i     (sel_we_s),
      .events_i     (events_i),
      .wdata_i      (bus.wdata),
      .cnt_o        (cnt_rd_s[i]),
      .sel_o        (sel_q_s),
      .ovf_set_o    (ovf_set_s[i])
    );

    assign sel_rd_s[i] = {{(CNT_WIDTH - SEL_W){1'b0}}, sel_q_s};
  end

  for (genvar j = NR_COUNTERS; j < NR_IDX; j++) begin : g_pad
    assign cnt_rd_s[j] = '0;
    assign sel_rd_s[j] = '0;
  end

  assign ctrl_we_s = bus.we && (bus.reg_sel == RS_CONTROL);

  // Write data narrowed to one bit per counter.
  always_comb begin
    wmask_s             = '0;
    wmask_s[RD_W-1:0]   = bus.wdata[RD_W-1:0];
  end

  // Next control state; a fresh overflow beats a same-cycle W1C.
  always_comb begin
    inh_s    = inh_r;
    ovf_en_s = ovf_en_r;
    ovf_s    = ovf_r;
    if (ctrl_we_s && (bus.addr == CTRL_INHIBIT)) begin
      inh_s = wmask_s;
    end else begin
      inh_s = inh_r;
    end
    if (ctrl_we_s && (bus.addr == CTRL_OVF_EN)) begin
      ovf_en_s = wmask_s;
    end else begin
      ovf_en_s = ovf_en_r;
    end
    if (ctrl_we_s && (bus.addr == CTRL_OVF)) begin
      ovf_s = (ovf_r & ~wmask_s) | ovf_set_s;
    end else begin
      ovf_s = ovf_r | ovf_set_s;
    end
  end

  // Control registers and the registered interrupt.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      inh_r    <= '0;
      ovf_r    <= '0;
      ovf_en_r <= '0;
      irq_r    <= 1'b0;
    end else begin
      inh_r    <= inh_s;
      ovf_r    <= ovf_s;
      ovf_en_r <= ovf_en_s;
      irq_r    <= |(ovf_s & ovf_en_s);
    end
  end

  // Read mux over registered state only.
  always_comb begin
    rdata_s = '0;
    case (bus.reg_sel)
      RS_COUNTER: rdata_s = cnt_rd_s[bus.addr];
      RS_EVSEL:   rdata_s = sel_rd_s[bus.addr];
      RS_CONTROL: begin
        case (bus.addr)
          CTRL_INHIBIT: rdata_s[RD_W-1:0] = inh_r[RD_W-1:0];
          CTRL_OVF:     rdata_s[RD_W-1:0] = ovf_r[RD_W-1:0];
          CTRL_OVF_EN:  rdata_s[RD_W-1:0] = ovf_en_r[RD_W-1:0];
          default:      rdata_s = '0;
        endcase
      end
      default:    rdata_s = '0;
    endcase
  end

  assign bus.rdata = rdata_s;
  assign irq_o     = irq_r;

endmodule

// File: tb/tb_hpm_counter_bank.sv
// Self-checking bench for hpm_counter_bank: directed scenarios followed by
// randomized traffic, all compared against a behavioural model of the bank.
module tb_hpm_counter_bank;
  import perf_pkg::*;

  localparam int NC = 8;
  localparam int CW = 64;
  localparam int NE = 16;
  localparam int IW = 2;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              dbg;
  logic [NE*IW-1:0]  ev;
  logic              irq;

  always #5 clk = ~clk;

  hpm_counter_bank_if #(.CNT_WIDTH(CW)) bus ();

  hpm_counter_bank #(
    .NR_COUNTERS (NC),
    .CNT_WIDTH   (CW),
    .NR_EVENTS   (NE),
    .INC_W       (IW)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .debug_mode_i (dbg),
    .events_i     (ev),
    .bus          (bus),
    .irq_o        (irq)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model state
  logic [63:0] m_cnt [NC];
  logic [3:0]  m_sel [NC];
  logic [7:0]  m_inh, m_ovf, m_en;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic void m_reset();
    for (int i = 0; i < NC; i++) begin
      m_cnt[i] = 64'd0;
      m_sel[i] = 4'd0;
    end
    m_inh = 8'd0;
    m_ovf = 8'd0;
    m_en  = 8'd0;
  endfunction

  function automatic logic [63:0] m_read(input logic [1:0] rs, input logic [4:0] a);
    if (rs == 2'd0) return (a < 5'(NC)) ? m_cnt[a[2:0]] : 64'd0;
    if (rs == 2'd1) return (a < 5'(NC)) ? {60'd0, m_sel[a[2:0]]} : 64'd0;
    if (rs == 2'd2) begin
      if (a == 5'd0) return {56'd0, m_inh};
      if (a == 5'd1) return {56'd0, m_ovf};
      if (a == 5'd2) return {56'd0, m_en};
    end
    return 64'd0;
  endfunction

  // One clock of the bank as seen from outside.
  function automatic void m_step(input logic [1:0] rs, input logic [4:0] a, input logic w,
                                 input logic [63:0] d, input logic [31:0] e, input logic dg);
    logic [63:0] ncnt [NC];
    logic [7:0]  nov;
    logic [64:0] s;
    int          inc;
    nov = m_ovf;
    if (w && rs == 2'd2 && a == 5'd1) nov = nov & ~d[7:0];
    for (int i = 0; i < NC; i++) begin
      inc = (m_sel[i] == 4'd0 || m_inh[i] || dg) ? 0 : int'((e >> (2 * m_sel[i])) & 32'd3);
      s   = {1'b0, m_cnt[i]} + 65'(inc);
      if (w && rs == 2'd0 && a == 5'(i)) begin
        ncnt[i] = d;
      end else begin
        ncnt[i] = s[63:0];
        if (s[64]) nov[i] = 1'b1;
      end
    end
    for (int i = 0; i < NC; i++) begin
      if (w && rs == 2'd1 && a == 5'(i)) m_sel[i] = (d < 64'(NE)) ? d[3:0] : 4'd0;
      m_cnt[i] = ncnt[i];
    end
    if (w && rs == 2'd2 && a == 5'd0) m_inh = d[7:0];
    if (w && rs == 2'd2 && a == 5'd2) m_en  = d[7:0];
    m_ovf = nov;
  endfunction

  // Drive one cycle, check read data and irq before the edge, then advance the model.
  task automatic cyc(input logic [1:0] rs, input logic [4:0] a, input logic w, input logic [63:0] d,
                     input logic [31:0] e, input logic dg, input logic r,
                     output logic [63:0] rv, output logic iv);
    bus.reg_sel = reg_sel_e'(rs);
    bus.addr    = a;
    bus.we      = w;
    bus.wdata   = d;
    ev          = e;
    dbg         = dg;
    rst_n       = r;
    #1;
    rv = bus.rdata;
    iv = irq;
    check_eq("rdata_vs_model", rv, m_read(rs, a));
    check_eq("irq_vs_model", {63'd0, iv}, {63'd0, |(m_ovf & m_en)});
    @(posedge clk);
    if (!r) m_reset();
    else    m_step(rs, a, w, d, e, dg);
    @(negedge clk);
  endtask

  task automatic wr(input logic [1:0] rs, input logic [4:0] a, input logic [63:0] d);
    logic [63:0] rv;
    logic        iv;
    cyc(rs, a, 1'b1, d, 32'd0, 1'b0, 1'b1, rv, iv);
  endtask

  task automatic rd(input logic [1:0] rs, input logic [4:0] a, output logic [63:0] rv, output logic iv);
    cyc(rs, a, 1'b0, 64'd0, 32'd0, 1'b0, 1'b1, rv, iv);
  endtask

  initial begin
    logic [63:0] rv;
    logic        iv;
    logic [1:0]  rs;
    logic [4:0]  a;
    logic        w;
    logic [63:0] d;

    // Initial reset, outputs unknown until the first edge.
    bus.reg_sel = RS_COUNTER;
    bus.addr    = 5'd0;
    bus.we      = 1'b0;
    bus.wdata   = 64'd0;
    ev          = 32'd0;
    dbg         = 1'b0;
    rst_n       = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    m_reset();

    // 1. Reset state and sel=0 counts nothing.
    for (int c = 0; c < 3; c++) begin
      for (int k = 0; k < 10; k++) begin
        rd(2'(c), 5'(k), rv, iv);
        check_eq("reset_read", rv, 64'd0);
      end
    end
    rd(2'd3, 5'd0, rv, iv);
    check_eq("reset_irq", {63'd0, iv}, 64'd0);
    for (int k = 0; k < 10; k++) cyc(2'd0, 5'(k % NC), 1'b0, 64'd0, 32'hFFFF_FFFF, 1'b0, 1'b1, rv, iv);
    for (int k = 0; k < NC; k++) begin
      rd(2'd0, 5'(k), rv, iv);
      check_eq("sel0_no_count", rv, 64'd0);
    end

    // 2. Multi-bit increment on counter 2 from EV_LOAD.
    wr(2'd1, 5'd2, 64'(EV_LOAD));
    for (int k = 0; k < 7; k++) begin
      cyc(2'd0, 5'd2, 1'b0, 64'd0, 32'd2 << (2 * int'(EV_LOAD)), 1'b0, 1'b1, rv, iv);
      if (k == 0) check_eq("inc_first_cycle", rv, 64'd0);
      if (k == 1) check_eq("inc_latency", rv, 64'd2);
    end
    rd(2'd0, 5'd2, rv, iv);
    check_eq("inc_total", rv, 64'd14);

    // 3. Wrap, overflow flag, interrupt and W1C.
    wr(2'd0, 5'd0, 64'hFFFF_FFFF_FFFF_FFFE);
    wr(2'd1, 5'd0, 64'd1);
    wr(2'd2, 5'd2, 64'd1);
    cyc(2'd0, 5'd0, 1'b0, 64'd0, 32'hC, 1'b0, 1'b1, rv, iv);
    check_eq("wrap_irq_before", {63'd0, iv}, 64'd0);
    rd(2'd0, 5'd0, rv, iv);
    check_eq("wrap_value", rv, 64'd1);
    check_eq("wrap_irq", {63'd0, iv}, 64'd1);
    rd(2'd2, 5'd1, rv, iv);
    check_eq("wrap_ovf_flag", rv, 64'd1);
    wr(2'd2, 5'd1, 64'd1);
    rd(2'd2, 5'd1, rv, iv);
    check_eq("w1c_flag", rv, 64'd0);
    check_eq("w1c_irq", {63'd0, iv}, 64'd0);

    // 4. Write beats increment; new wrap beats W1C.
    wr(2'd1, 5'd1, 64'd1);
    wr(2'd0, 5'd1, 64'd50);
    cyc(2'd0, 5'd1, 1'b1, 64'd100, 32'hC, 1'b0, 1'b1, rv, iv);
    check_eq("wr_old_value", rv, 64'd50);
    rd(2'd0, 5'd1, rv, iv);
    check_eq("wr_beats_inc", rv, 64'd100);
    wr(2'd0, 5'd0, 64'hFFFF_FFFF_FFFF_FFFF);
    cyc(2'd2, 5'd1, 1'b1, 64'd1, 32'h4, 1'b0, 1'b1, rv, iv);
    rd(2'd2, 5'd1, rv, iv);
    check_eq("ovf_beats_w1c", rv, 64'd1);
    check_eq("ovf_beats_w1c_irq", {63'd0, iv}, 64'd1);

    // 5. Inhibit and debug gating.
    wr(2'd2, 5'd1, 64'hFF);
    wr(2'd0, 5'd0, 64'd0);
    wr(2'd0, 5'd1, 64'd0);
    wr(2'd2, 5'd0, 64'd2);
    repeat (5) cyc(2'd0, 5'd0, 1'b0, 64'd0, 32'hC, 1'b0, 1'b1, rv, iv);
    rd(2'd0, 5'd0, rv, iv);
    check_eq("inh_other_counts", rv, 64'd15);
    rd(2'd0, 5'd1, rv, iv);
    check_eq("inh_frozen", rv, 64'd0);
    wr(2'd2, 5'd0, 64'd0);
    repeat (3) cyc(2'd0, 5'd0, 1'b0, 64'd0, 32'hC, 1'b1, 1'b1, rv, iv);
    cyc(2'd0, 5'd3, 1'b1, 64'd77, 32'hC, 1'b1, 1'b1, rv, iv);
    rd(2'd0, 5'd0, rv, iv);
    check_eq("debug_frozen", rv, 64'd15);
    rd(2'd0, 5'd3, rv, iv);
    check_eq("debug_write_lands", rv, 64'd77);

    // 6. Illegal accesses.
    wr(2'd1, 5'd4, 64'd20);
    rd(2'd1, 5'd4, rv, iv);
    check_eq("sel_out_of_range", rv, 64'd0);
    wr(2'd0, 5'd9, 64'd123);
    wr(2'd1, 5'd9, 64'd3);
    wr(2'd2, 5'd3, 64'hFF);
    wr(2'd3, 5'd0, 64'hFF);
    rd(2'd0, 5'd9, rv, iv);
    check_eq("cnt_addr9", rv, 64'd0);
    rd(2'd2, 5'd0, rv, iv);
    check_eq("ctrl_untouched", rv, 64'd0);

    // Reset mid-operation drops the in-flight write.
    cyc(2'd0, 5'd5, 1'b1, 64'd999, 32'hFFFF_FFFF, 1'b0, 1'b0, rv, iv);
    rd(2'd0, 5'd5, rv, iv);
    check_eq("reset_drops_write", rv, 64'd0);
    rd(2'd0, 5'd2, rv, iv);
    check_eq("reset_clears_cnt", rv, 64'd0);

    // Randomized traffic against the model.
    for (int k = 0; k < 600; k++) begin
      rs = 2'($urandom_range(0, 3));
      if (rs == 2'd2) a = 5'($urandom_range(0, 3));
      else            a = ($urandom_range(0, 5) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
      w  = ($urandom_range(0, 2) == 0);
      case (rs)
        2'd0:    d = ($urandom_range(0, 1) == 1) ? 64'hFFFF_FFFF_FFFF_FFF0 + 64'($urandom_range(0, 15))
                                                 : {$urandom, $urandom};
        2'd1:    d = 64'($urandom_range(0, 20));
        default: d = 64'($urandom_range(0, 255));
      endcase
      cyc(rs, a, w, d, $urandom, ($urandom_range(0, 7) == 0), ($urandom_range(0, 99) != 0), rv, iv);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
